// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The helpers derive frame length and watchdog limits from clock and baud rate.
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int CLK_HZ         = 50_000_000;
    localparam int BAUD           = 115200;
    localparam int BITS_PER_FRAME = 10;  // start + 8 data + stop

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } arb_state_t;

    function automatic int frame_cycles(input int clk_hz, input int baud);
        return (clk_hz / baud) * BITS_PER_FRAME;
    endfunction

    function automatic int done_timeout_cycles(input int clk_hz, input int baud,
                                               input int margin_pct);
        return (frame_cycles(clk_hz, baud) * (100 + margin_pct)) / 100;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request at or above i_ptr, wrapping at N.
// Kept generic so RX/TX muxes elsewhere can share it.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int IDX_W = $clog2(N);

    always_comb begin : pick
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 tx core between N_REQ byte producers with round-robin arbitration
// and frame locking; watchdogs recover from a dead core or a stalled frame owner.
//   state     | meaning
//   IDLE      | no owner; pick next requester round-robin from rr_ptr
//   LAUNCH    | byte captured in tx_din; tx_start pulses this cycle
//   WAIT_DONE | core busy; wait for tx_done_tick or done watchdog
//   HOLD      | mid-frame; only the owner may hand over its next byte
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = UART_DATA_W,
    parameter int DONE_TIMEOUT = 8000,
    parameter int HOLD_TIMEOUT = 1000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    input  logic [N_REQ-1:0]          i_req_last,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic [DATA_W-1:0]         o_tx_din,
    output logic                      o_tx_start,
    input  logic                      i_tx_done_tick,
    output logic                      o_busy,
    output logic [$clog2(N_REQ)-1:0]  o_grant_id,
    output logic                      o_timeout_err
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int MAX_TO = (DONE_TIMEOUT > HOLD_TIMEOUT) ? DONE_TIMEOUT : HOLD_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_TO) + 1;

    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_grant_id;
    logic [DATA_W-1:0] r_tx_din;
    logic              r_last_q;

    logic [N_REQ-1:0]  w_pick_grant;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [IDX_W-1:0]  w_owner_nxt;
    logic              w_owner_valid;
    logic              w_accept;
    logic              w_release;
    logic              w_timeout;
    logic [N_REQ-1:0]  w_ready;
    logic [DATA_W-1:0] w_req_bytes [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign w_req_bytes[g] = i_req_data[g*DATA_W +: DATA_W];
    end

    rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_owner_valid = i_req_valid[r_grant_id];
    assign w_owner_nxt   = (r_grant_id == IDX_LAST) ? '0 : r_grant_id + IDX_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_accept    = 1'b0;
        w_sel_idx   = r_grant_id;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_ready     = w_pick_grant;
                    w_accept    = 1'b1;
                    w_sel_idx   = w_pick_idx;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // a tick arriving in the expiry cycle still counts as success
                if (i_tx_done_tick) begin
                    if (r_last_q) begin
                        w_release   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end else if (r_cnt >= DONE_LAST) begin
                    w_timeout   = 1'b1;
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (w_owner_valid) begin
                    w_ready[r_grant_id] = 1'b1;
                    w_accept            = 1'b1;
                    w_state_nxt         = LAUNCH;
                end else if (r_cnt >= HOLD_LAST) begin
                    w_timeout   = 1'b1;
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (i_rst) begin
            w_ready   = '0;
            w_timeout = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_tx_din   <= '0;
            r_last_q   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_tx_din   <= w_req_bytes[w_sel_idx];
                r_grant_id <= w_sel_idx;
                r_last_q   <= i_req_last[w_sel_idx];
            end
            if (w_release) begin
                r_rr_ptr <= w_owner_nxt;
            end
        end
    end

    assign o_req_ready   = w_ready;
    assign o_tx_din      = r_tx_din;
    assign o_tx_start    = (r_state == LAUNCH);
    assign o_busy        = (r_state != IDLE);
    assign o_grant_id    = r_grant_id;
    assign o_timeout_err = w_timeout;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter core (8N1, 50 MHz clk) between N_REQ byte producers.
- Round-robin arbitration with frame locking: a requester keeps the transmitter until it sends a byte flagged last, so multi-byte frames stay contiguous on the tx line.
- Sequences the core: presents tx_din, pulses tx_start, waits for tx_done_tick. Watchdogs guard against a dead core or a stalled frame owner.
- Sits between the producers and the tx core inside top.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
DONE_TIMEOUT, 8000, max clk cycles from tx_start to tx_done_tick (one frame at 115200 baud is 4340)
HOLD_TIMEOUT, 1000, max clk cycles a locked owner may leave req_valid low mid-frame

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
req_valid  in  N_REQ  per-requester byte available
req_data  in  N_REQ*DATA_W  bytes; requester i uses bits [i*DATA_W +: DATA_W]
req_last  in  N_REQ  byte is the last of its frame
req_ready  out  N_REQ  byte accepted this cycle (transfer = valid & ready)
tx_din  out  DATA_W  byte to the tx core, registered
tx_start  out  1  one-cycle start pulse to the tx core
tx_done_tick  in  1  one-cycle pulse from the tx core: frame finished
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(N_REQ)  current/last owner index
timeout_err  out  1  one-cycle pulse on any watchdog expiry

Behaviour:
- Reset, synchronous, any state. State=IDLE, rr_ptr=0, grant_id=0, tx_din=0, tx_start=0, req_ready=0, busy=0, timeout_err=0, lock cleared, counters=0.
- Reset mid-transfer aborts the transfer. The tx core must be reset by the same rst.
- FSM states: IDLE, LAUNCH, WAIT_DONE, HOLD.
- IDLE:
  - Winner = first i with req_valid[i] set, searching from rr_ptr upward with wrap at N_REQ.
  - req_ready[winner]=1 combinationally in the same cycle.
  - On that edge: tx_din<=data, grant_id<=winner, last_q<=req_last[winner]; next state LAUNCH.
  - No valid: stay IDLE, all req_ready low.
- LAUNCH: tx_start=1 for exactly one cycle; next state WAIT_DONE.
  - Latency: accept edge to tx_start high = 1 cycle.
- WAIT_DONE:
  - req_ready all 0; counter increments every cycle.
  - On tx_done_tick with last_q=1: next IDLE, rr_ptr<=grant_id+1 (mod N_REQ).
  - On tx_done_tick with last_q=0: next HOLD.
  - Counter reaches DONE_TIMEOUT with no tick: timeout_err pulses, lock released, rr_ptr<=grant_id+1, next IDLE.
  - Tick in the same cycle as expiry: the tick wins, no error.
- HOLD:
  - Only the owner may transfer: req_ready[grant_id]=req_valid[grant_id]; all other requesters are ignored even if valid.
  - On transfer: capture data and last as in IDLE, next LAUNCH, counter cleared.
  - Owner valid low for HOLD_TIMEOUT cycles: timeout_err pulses, rr_ptr<=grant_id+1, next IDLE.
  - Owner valid in the expiry cycle: the transfer wins.
- At most one req_ready bit is high in any cycle.
- tx_start is never high in two consecutive cycles.
- tx_start never rises while a core frame is outstanding.
- tx_done_tick outside WAIT_DONE is ignored.
- Requesters must hold data and last stable while valid is high. Dropping valid before ready is allowed.
- Counters: width $clog2(max(DONE_TIMEOUT,HOLD_TIMEOUT))+1, saturating, cleared on each state entry.

Decomposition:
- Package uart_pkg:
  - DATA_W default.
  - Typedef arb_state_t (enum IDLE, LAUNCH, WAIT_DONE, HOLD).
  - CLK_HZ=50_000_000, BAUD=115200 constants, with DONE_TIMEOUT derivation helper.
- One sub-module rr_picker: combinational round-robin priority select.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, index, any.
  - Reusable for future RX/TX muxes.
- Top of this block: FSM, capture register, watchdog counter.

Test Plan:
- Single byte: req_valid[2]=1, data 8'hBB, last=1 from IDLE.
  - -> req_ready[2] for 1 cycle; next cycle tx_start=1, tx_din=8'hBB.
  - -> after tx_done_tick, busy=0 and rr_ptr=3.
- Contention: all 4 valid, each with last=1 (bytes 8'h10..8'h13), rr_ptr=0.
  - -> tx_din sequence 8'h10, 8'h11, 8'h12, 8'h13.
  - -> next round restarts at requester 0.
- Frame lock: requester 1 sends 8'hE7 (last=0) then 8'hFF (last=1) while requester 0 holds valid throughout.
  - -> requester 0 receives no req_ready until both bytes are done.
  - -> requester 0's byte is then sent.
- Done watchdog: tx_done_tick tied low after tx_start.
  - -> timeout_err pulses exactly DONE_TIMEOUT cycles later; state IDLE; the next requester is served.
- Hold watchdog and boundary:
  - Owner drops valid after a last=0 byte -> timeout_err after HOLD_TIMEOUT cycles.
  - Rerun with owner valid asserted in the expiry cycle -> transfer accepted, no error.
- Reset mid-WAIT_DONE: assert rst for 1 cycle.
  - -> all outputs at reset values next cycle, rr_ptr=0.
  - -> no tx_start until a new valid arrives.
